// File: rtl/io_irq_hub.sv
// Interrupt hub: registered src, edge/level pending, lowest-index priority, IDLE/REQ/CLR handshake.
// Reads return one cycle after r_en; writes land one cycle after w_en; no backpressure (strobe-driven bus).
module io_irq_hub #(
  parameter logic [7:0] IRQ_ADDRESS = 8'hC0,
  parameter int         NUM_SRC     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         din,
  input  logic [7:0]         address,
  input  logic               w_en,
  input  logic               r_en,
  output logic [7:0]         dout,
  input  logic [NUM_SRC-1:0] src,
  output logic [NUM_SRC-1:0] src_clr,
  output logic               irq,
  input  logic               irq_ack,
  output logic [2:0]         irq_vector
);

  localparam logic [7:0] ADDR_EN   = IRQ_ADDRESS;
  localparam logic [7:0] ADDR_PEND = IRQ_ADDRESS + 8'd1;
  localparam logic [7:0] ADDR_MODE = IRQ_ADDRESS + 8'd2;
  localparam logic [7:0] ADDR_VEC  = IRQ_ADDRESS + 8'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [2:0]         vec_q, vec_d;
  logic [7:0]         dout_q, dout_d;

  logic [NUM_SRC-1:0] set_bits;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] vec_oh;
  logic               vec_hit;
  logic [2:0]         sel;
  logic [7:0]         rd_val;
  logic               unused_din;

  // din bits at or above NUM_SRC are deliberately dropped.
  assign unused_din = ^din;

  always_comb begin
    active  = pend_q & en_q;
    vec_oh  = '0;
    sel     = '0;
    src_clr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = 3'(i);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      vec_oh[i]  = (vec_q == 3'(i));
      src_clr[i] = (state_q == S_CLR) && (vec_q == 3'(i));
    end
    vec_hit = |(active & vec_oh);
  end

  always_comb begin
    rd_val = '0;
    if (address == ADDR_EN) begin
      rd_val[NUM_SRC-1:0] = en_q;
    end else if (address == ADDR_PEND) begin
      rd_val[NUM_SRC-1:0] = pend_q;
    end else if (address == ADDR_MODE) begin
      rd_val[NUM_SRC-1:0] = mode_q;
    end else if (address == ADDR_VEC) begin
      rd_val = {(state_q == S_REQ), 4'b0000, vec_q};
    end
  end

  always_comb begin
    src_d      = src;
    src_prev_d = src_q;
    en_d       = en_q;
    mode_d     = mode_q;
    state_d    = state_q;
    vec_d      = vec_q;
    dout_d     = r_en ? rd_val : 8'h00;
    clr_bits   = '0;
    set_bits   = (src_q & ~src_prev_q & mode_q) | (src_q & ~mode_q);

    if (w_en) begin
      if (address == ADDR_EN)   en_d     = din[NUM_SRC-1:0];
      if (address == ADDR_MODE) mode_d   = din[NUM_SRC-1:0];
      if (address == ADDR_PEND) clr_bits = din[NUM_SRC-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (|active) begin
          vec_d   = sel;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Losing the serviced bit before ack withdraws the request.
        if (!vec_hit) begin
          state_d = S_IDLE;
        end else if (irq_ack) begin
          clr_bits = clr_bits | vec_oh;
          state_d  = S_CLR;
        end
      end
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A set in the same cycle as a clear keeps the bit pending.
    pend_d = (pend_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      pend_q     <= '0;
      mode_q     <= '0;
      src_q      <= '0;
      src_prev_q <= '0;
      vec_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      src_prev_q <= src_prev_d;
      vec_q      <= vec_d;
      dout_q     <= dout_d;
    end
  end

  assign irq        = (state_q == S_REQ);
  assign irq_vector = vec_q;
  assign dout       = dout_q;

endmodule

// File: doc/io_irq_hub.md
IO_IRQ_HUB -- requirements
Module: io_irq_hub

Interface
REQ-001 Parameter IRQ_ADDRESS, default 8'hC0, base of the 4-register window (BASE+0..BASE+3) on the 8-bit io address bus.
REQ-002 Parameter NUM_SRC, default 4, number of interrupt sources; legal range 1..8.
REQ-003 clk  input  1  system clock; the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 din  input  8  write data from CPU.
REQ-006 address  input  8  io address, low byte.
REQ-007 w_en  input  1  write strobe, one cycle per write.
REQ-008 r_en  input  1  read strobe, one cycle per read.
REQ-009 dout  output  8  read data; shared OR-bus; 8'h00 whenever not driving a valid read.
REQ-010 src  input  NUM_SRC  peripheral interrupt flags.
REQ-011 src_clr  output  NUM_SRC  one-cycle clear pulses back to peripherals.
REQ-012 irq  output  1  interrupt request to CPU.
REQ-013 irq_ack  input  1  CPU acknowledge, one-cycle pulse.
REQ-014 irq_vector  output  3  index of the source being serviced.

Function
REQ-015 Register map: BASE+0 ENABLE (R/W); BASE+1 PENDING (R, write-1-to-clear); BASE+2 MODE (R/W, bit=1 edge, 0 level); BASE+3 VECTOR (R only: bit7 = irq, bits2:0 = irq_vector).
REQ-016 Bits at or above NUM_SRC: writes ignored, read 0.
REQ-017 Read latency 1 cycle: dout valid the cycle after r_en with matching address, 8'h00 in every other cycle.
REQ-018 Writes take effect the cycle after w_en; writes to VECTOR ignored.
REQ-019 Edge mode: src registered once; pending[i] sets on 0->1 transition of registered src[i].
REQ-020 Level mode: pending[i] sets in any cycle registered src[i]=1.
REQ-021 Pending sets regardless of ENABLE; ENABLE gates only request generation.
REQ-022 Simultaneous set and clear (W1C or ack) of the same bit in one cycle: set wins.
REQ-023 Active set = pending & ENABLE; selected source = lowest-index active bit (index 0 highest priority).
REQ-024 FSM states IDLE, REQ, CLR.
REQ-025 IDLE: irq=0; on nonempty active set, latch selected index into irq_vector, go REQ next cycle.
REQ-026 REQ: irq=1; irq_vector frozen even if higher-priority bits arrive; irq_ack -> clear pending[irq_vector], go CLR.
REQ-027 REQ: if the serviced bit is cleared by W1C or ENABLE before ack, drop irq, return to IDLE next cycle.
REQ-028 CLR: src_clr[irq_vector]=1 for exactly one cycle, irq=0; then IDLE.
REQ-029 irq_ack outside REQ ignored; src_clr is 0 outside CLR.
REQ-030 Level source still high after its src_clr pulse re-pends in the following cycle (REQ-020).
REQ-031 Back-to-back: minimum 1 IDLE cycle between CLR and next REQ.

Reset
REQ-032 When rst=1 at a clock edge: ENABLE, PENDING, MODE = 0, registered src = 0, FSM=IDLE, irq=0, irq_vector=0, src_clr=0, dout=8'h00.
REQ-033 Reset mid-REQ or mid-CLR aborts with no src_clr pulse; reset dominates all writes, sets and acks in the same cycle.
REQ-034 First edge detection after reset treats src as previously 0.

Verification
REQ-035 Write ENABLE=8'h0F, MODE=8'h0F, pulse src[2] -> PENDING reads 8'h04, irq=1 two cycles after edge, irq_vector=2.
REQ-036 src=4'b1010 edge with ENABLE=8'h0F -> vector 1; ack -> src_clr=4'b0010 one cycle; then vector 3 served.
REQ-037 In REQ with vector 3, raise src[0] edge -> vector stays 3 until ack; next request vector 0.
REQ-038 Level mode src[0] held high, ack -> src_clr[0] pulse, pending re-sets, irq reasserts after IDLE cycle.
REQ-039 W1C PENDING=8'h04 same cycle as new src[2] edge -> PENDING bit 2 remains 1.
REQ-040 Assert rst during CLR -> src_clr stays 0, all registers read 8'h00, irq=0; read of unmapped address -> dout 8'h00.
